sample_ram_controller: RTL

// Circular dual-channel sample memory directly downstream of buffer_controller. Stores {ch1,ch2}
// on every write_enable cycle; on a send_data request streams the most recent N samples, oldest

---
 rtl/sample_ram_controller.sv | 74 +++++++
 1 files changed

// File: rtl/sample_ram_controller.sv
// sample_ram_controller: circular {ch1,ch2} sample store that streams the newest N samples, oldest first, as bytes
module sample_ram_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ch1_in,
    input  logic [DATA_WIDTH-1:0] ch2_in,
    input  logic                  write_enable,
    input  logic [15:0]           num_samples,
    input  logic                  send_data,
    output logic                  data_sent,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LATCH, ST_TX1, ST_TX2, ST_DONE} state_t;
    state_t                    r_state, w_next;
    logic [2*DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [2*DATA_WIDTH-1:0]   r_rd_q;
    logic [ADDR_WIDTH-1:0]     r_wr_ptr, r_rd_ptr, w_wr_next;
    logic [16:0]               r_remaining, w_n;
    logic [DATA_WIDTH-1:0]     r_ch1_buf, r_ch2_buf;
    logic                      r_send_q, w_wr, w_start;
    assign w_wr      = !rst && r_state == ST_IDLE && write_enable;
    assign w_start   = r_state == ST_IDLE && send_data && !r_send_q;
    assign w_wr_next = r_wr_ptr + ADDR_WIDTH'(w_wr);
    assign w_n       = ({1'b0, num_samples} > 17'(DEPTH)) ? 17'(DEPTH) : {1'b0, num_samples};
    // Single port: a write in idle takes the port, otherwise it reads rd_ptr
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {ch1_in, ch2_in};
        else r_rd_q <= r_mem[r_rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_send_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_send_q <= send_data;
            r_wr_ptr <= w_wr_next;
            // Start address uses the post-write pointer so a same-cycle sample is the newest sent
            if (w_start) begin
                r_rd_ptr    <= w_wr_next - w_n[ADDR_WIDTH-1:0];
                r_remaining <= w_n;
            end
            if (r_state == ST_LATCH) begin
                {r_ch1_buf, r_ch2_buf} <= r_rd_q;
                r_rd_ptr               <= r_rd_ptr + 1'b1;
                r_remaining            <= r_remaining - 1'b1;
            end
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_start ? ((w_n == '0) ? ST_DONE : ST_FETCH) : ST_IDLE;
            ST_FETCH: w_next = ST_LATCH;
            ST_LATCH: w_next = ST_TX1;
            ST_TX1:   w_next = tx_ready ? ST_TX2 : ST_TX1;
            ST_TX2:   w_next = tx_ready ? ((r_remaining == '0) ? ST_DONE : ST_FETCH) : ST_TX2;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end
    assign tx_valid  = r_state == ST_TX1 || r_state == ST_TX2;
    assign tx_data   = (r_state == ST_TX1) ? r_ch1_buf : (r_state == ST_TX2) ? r_ch2_buf : '0;
    assign data_sent = r_state == ST_DONE;
    assign busy      = r_state != ST_IDLE;
endmodule
